adain_seq_host: RTL and testbench

//  Initiator side of the AdaIN control-unit command interface. Issues the three per-channel

---
 rtl/adain_seq_host.sv | 153 +++++++++++++++
 tb/tb_adain_seq_host.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adain_seq_host.sv
// adain_seq_host -- initiator side of the AdaIN control-unit command interface.
// For each of C channels it issues MEAN, VAR and NORM commands on start, waits for
// the matching done code (NORM ends when N*N output pixels have been written),
// serves CU pixel requests with feature-buffer read addresses and steers output
// pixels to output-buffer write addresses.
// Ports:
//   clk, rst_n      clock / synchronous active-low reset
//   go, cfg_n, cfg_c run request and latched side length / channel count
//   busy, all_done  run in progress / 1-cycle completion pulse
//   err             sticky watchdog-timeout or pixel-overrun flag
//   start, done     command code to CU / completion code from CU
//   mac_en, out_en  CU pixel request / CU output pixel valid
//   ch_idx          current channel
//   rd_en, rd_addr  feature-buffer read strobe and address
//   wr_en, wr_addr  output-buffer write strobe and address
module adain_seq_host #(
  parameter int unsigned N_MAX  = 256,
  parameter int unsigned C_MAX  = 512,
  parameter int unsigned ADDR_W = 25,
  parameter int unsigned TMO_W  = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       go,
  input  logic [$clog2(N_MAX+1)-1:0] cfg_n,
  input  logic [$clog2(C_MAX+1)-1:0] cfg_c,
  output logic                       busy,
  output logic                       all_done,
  output logic                       err,
  output logic [1:0]                 start,
  input  logic [1:0]                 done,
  input  logic                       mac_en,
  input  logic                       out_en,
  output logic [$clog2(C_MAX)-1:0]   ch_idx,
  output logic                       rd_en,
  output logic [ADDR_W-1:0]          rd_addr,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_addr
);

  localparam int unsigned CW = $clog2(C_MAX+1);
  // Trip one count early: err shows 2^TMO_W-1 cycles after the last sampled activity.
  localparam logic [TMO_W-1:0] WD_TRIP = {{(TMO_W-1){1'b1}}, 1'b0};

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ISS_MEAN = 4'd1,
    WT_MEAN  = 4'd2,
    ISS_VAR  = 4'd3,
    WT_VAR   = 4'd4,
    ISS_NORM = 4'd5,
    WT_NORM  = 4'd6,
    NEXT_CH  = 4'd7,
    FIN      = 4'd8
  } state_t;

  state_t            state, nxt;
  logic [CW-1:0]     c_r;
  logic [ADDR_W-1:0] nn, ch_base, pix, wcnt;
  logic [TMO_W-1:0]  wd;
  logic              in_wt, wd_tc, last_ch, degen, pix_full, last_wr;

  assign in_wt    = (state == WT_MEAN) || (state == WT_VAR) || (state == WT_NORM);
  assign wd_tc    = in_wt && (wd == WD_TRIP) && !mac_en && !out_en;
  assign last_ch  = (CW'(ch_idx) == (c_r - CW'(1)));
  assign degen    = (cfg_c == '0) || (cfg_n == '0);
  assign pix_full = (pix == nn);
  assign last_wr  = out_en && (wcnt == (nn - ADDR_W'(1)));

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (go) nxt = degen ? FIN : ISS_MEAN;
      ISS_MEAN: nxt = WT_MEAN;
      WT_MEAN:  if (done == 2'b01) nxt = ISS_VAR;  else if (wd_tc) nxt = IDLE;
      ISS_VAR:  nxt = WT_VAR;
      WT_VAR:   if (done == 2'b10) nxt = ISS_NORM; else if (wd_tc) nxt = IDLE;
      ISS_NORM: nxt = WT_NORM;
      // done==11 is only an early notice; the write count ends NORM.
      WT_NORM:  if (last_wr) nxt = NEXT_CH;        else if (wd_tc) nxt = IDLE;
      NEXT_CH:  nxt = last_ch ? FIN : ISS_MEAN;
      FIN:      nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_comb begin
    start = 2'b00;
    case (state)
      ISS_MEAN: start = 2'b01;
      ISS_VAR:  start = 2'b10;
      ISS_NORM: start = 2'b11;
      default:  start = 2'b00;
    endcase
  end

  assign busy     = (state != IDLE) && (state != FIN);
  assign all_done = (state == FIN);
  assign rd_en    = in_wt && mac_en && !pix_full;
  assign wr_en    = (state == WT_NORM) && out_en;
  assign rd_addr  = ch_base + pix;
  assign wr_addr  = ch_base + wcnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      err     <= 1'b0;
      c_r     <= '0;
      nn      <= '0;
      ch_idx  <= '0;
      ch_base <= '0;
      pix     <= '0;
      wcnt    <= '0;
      wd      <= '0;
    end else begin
      state <= nxt;
      if ((nxt != state) || mac_en || out_en || !in_wt) wd <= '0;
      else                                              wd <= wd + TMO_W'(1);

      case (state)
        IDLE: if (go) begin
          err     <= 1'b0;
          c_r     <= cfg_c;
          nn      <= ADDR_W'(cfg_n) * ADDR_W'(cfg_n);
          ch_idx  <= '0;
          ch_base <= '0;
          pix     <= '0;
          wcnt    <= '0;
        end
        WT_MEAN, WT_VAR, WT_NORM: begin
          if (mac_en) begin
            if (pix_full) err <= 1'b1;
            else          pix <= pix + ADDR_W'(1);
          end
          if ((state == WT_NORM) && out_en) wcnt <= wcnt + ADDR_W'(1);
          if (wd_tc) err <= 1'b1;
          if ((nxt == ISS_VAR) || (nxt == ISS_NORM)) pix <= '0;
        end
        NEXT_CH: begin
          pix  <= '0;
          wcnt <= '0;
          // ch_idx holds the last channel after the run instead of wrapping.
          if (!last_ch) begin
            ch_idx  <= ch_idx + 1'b1;
            ch_base <= ch_base + nn;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adain_seq_host.sv
// Testbench for adain_seq_host: a behavioural CU drives done/mac_en/out_en with
// random gaps; a monitor logs start events, reads, writes and all_done pulses;
// expectations are built from channel/pixel arithmetic.
module tb_adain_seq_host;
  localparam int unsigned TB_NMAX = 16;
  localparam int unsigned TB_CMAX = 8;
  localparam int unsigned TB_AW   = 12;
  localparam int unsigned TB_TMO  = 8;
  localparam int unsigned NW = $clog2(TB_NMAX+1);
  localparam int unsigned CW = $clog2(TB_CMAX+1);
  localparam int unsigned IW = $clog2(TB_CMAX);

  logic clk = 1'b0;
  logic rst_n, go, busy, all_done, err, mac_en, out_en, rd_en, wr_en;
  logic [NW-1:0] cfg_n;
  logic [CW-1:0] cfg_c;
  logic [1:0] start, done;
  logic [IW-1:0] ch_idx;
  logic [TB_AW-1:0] rd_addr, wr_addr;

  adain_seq_host #(.N_MAX(TB_NMAX), .C_MAX(TB_CMAX), .ADDR_W(TB_AW), .TMO_W(TB_TMO)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .cfg_n(cfg_n), .cfg_c(cfg_c),
    .busy(busy), .all_done(all_done), .err(err), .start(start), .done(done),
    .mac_en(mac_en), .out_en(out_en), .ch_idx(ch_idx), .rd_en(rd_en),
    .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_mac_cyc = 0;
  int cu_npix, cu_extra, cu_stall;

  always @(posedge clk) cyc <= cyc + 1;

  int mon_st[$];
  int mon_rd[$];
  int mon_wr[$];
  int mon_done = 0;
  always @(negedge clk) begin
    if (start != 2'b00) mon_st.push_back(int'(ch_idx) * 4 + int'(start));
    if (rd_en) mon_rd.push_back(int'(rd_addr));
    if (wr_en) mon_wr.push_back(int'(wr_addr));
    if (all_done) mon_done++;
  end

  // ---------------- behavioural control unit ----------------
  task automatic cu_tick(output bit ab);
    @(posedge clk); #1;
    ab = !rst_n;
    if (ab) begin mac_en = 1'b0; out_en = 1'b0; done = 2'b00; end
  endtask

  task automatic cu_phase(input logic [1:0] ph);
    bit ab;
    int reads, gap;
    cu_tick(ab); if (ab) return;
    if (ph == 2'b11) done = 2'b11;
    reads = cu_npix + ((ph == 2'b01) ? cu_extra : 0);
    for (int i = 0; i < reads; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin cu_tick(ab); if (ab) return; end
      mac_en = 1'b1;
      last_mac_cyc = cyc;
      cu_tick(ab); if (ab) return;
      mac_en = 1'b0;
    end
    if (ph == 2'b01) begin
      done = 2'b01; cu_tick(ab); done = 2'b00;
    end else if (ph == 2'b10) begin
      if (cu_stall == 0) begin done = 2'b10; cu_tick(ab); done = 2'b00; end
    end else begin
      for (int i = 0; i < cu_npix; i++) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin cu_tick(ab); if (ab) return; end
        out_en = 1'b1;
        cu_tick(ab); if (ab) return;
        out_en = 1'b0;
      end
      done = 2'b00;
    end
  endtask

  initial begin
    mac_en = 1'b0; out_en = 1'b0; done = 2'b00;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && start != 2'b00) cu_phase(start);
    end
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic pulse_go(input int n, input int c);
    @(posedge clk); #1;
    cfg_n = NW'(n); cfg_c = CW'(c); go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_all_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (all_done) begin ok = 1'b1; return; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (all_done !== 1'b0) begin n_fail++; $display("FAIL reset_all_done: got %b want 0", all_done); end
    n_checks++; if (err !== 1'b0)      begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_checks++; if (start !== 2'b00)   begin n_fail++; $display("FAIL reset_start: got %b want 00", start); end
    n_checks++; if (rd_en !== 1'b0 || wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got rd %b wr %b want 0 0", rd_en, wr_en); end
    n_checks++; if (ch_idx !== '0 || rd_addr !== '0 || wr_addr !== '0) begin
      n_fail++; $display("FAIL reset_addr: got ch %0d rd %0d wr %0d want 0 0 0", ch_idx, rd_addr, wr_addr); end
    rst_n = 1'b1;
  endtask

  // Full channel loop: every start event, read and write compared with the model.
  task automatic test_channel_loop(input int n, input int c, input bit inject, input bit exp_err, input string tag);
    int exp_st[$], exp_rd[$], exp_wr[$];
    int nn, st0, rd0, wr0, d0;
    bit ok;
    nn = n * n;
    for (int ch = 0; ch < c; ch++) begin
      for (int ph = 1; ph <= 3; ph++) exp_st.push_back(ch * 4 + ph);
      for (int rep = 0; rep < 3; rep++)
        for (int p = 0; p < nn; p++) exp_rd.push_back(ch * nn + p);
      for (int p = 0; p < nn; p++) exp_wr.push_back(ch * nn + p);
    end
    st0 = mon_st.size(); rd0 = mon_rd.size(); wr0 = mon_wr.size(); d0 = mon_done;
    cu_npix = nn;
    pulse_go(n, c);
    if (inject) begin
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy: got %b want 1", tag, busy); end
      cfg_n = NW'(n + 1); cfg_c = CW'(c + 1); go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
    end
    wait_all_done(8000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL %s_timeout: got no all_done want all_done within 8000 cycles", tag); end
    repeat (4) @(negedge clk);
    n_checks++; if (mon_done - d0 != 1) begin n_fail++; $display("FAIL %s_done_count: got %0d want 1", tag, mon_done - d0); end
    n_checks++; if (err !== exp_err) begin n_fail++; $display("FAIL %s_err: got %b want %b", tag, err, exp_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_end: got %b want 0", tag, busy); end
    n_checks++; if (mon_st.size() - st0 != exp_st.size()) begin
      n_fail++; $display("FAIL %s_start_count: got %0d want %0d", tag, mon_st.size() - st0, exp_st.size()); end
    n_checks++; if (mon_rd.size() - rd0 != exp_rd.size()) begin
      n_fail++; $display("FAIL %s_rd_count: got %0d want %0d", tag, mon_rd.size() - rd0, exp_rd.size()); end
    n_checks++; if (mon_wr.size() - wr0 != exp_wr.size()) begin
      n_fail++; $display("FAIL %s_wr_count: got %0d want %0d", tag, mon_wr.size() - wr0, exp_wr.size()); end
    for (int i = 0; i < exp_st.size() && st0 + i < mon_st.size(); i++) begin
      n_checks++; if (mon_st[st0+i] != exp_st[i]) begin
        n_fail++; $display("FAIL %s_start[%0d]: got ch %0d code %0d want ch %0d code %0d", tag, i,
                           mon_st[st0+i] / 4, mon_st[st0+i] % 4, exp_st[i] / 4, exp_st[i] % 4); end
    end
    for (int i = 0; i < exp_rd.size() && rd0 + i < mon_rd.size(); i++) begin
      n_checks++; if (mon_rd[rd0+i] != exp_rd[i]) begin
        n_fail++; $display("FAIL %s_rd_addr[%0d]: got %0d want %0d", tag, i, mon_rd[rd0+i], exp_rd[i]); end
    end
    for (int i = 0; i < exp_wr.size() && wr0 + i < mon_wr.size(); i++) begin
      n_checks++; if (mon_wr[wr0+i] != exp_wr[i]) begin
        n_fail++; $display("FAIL %s_wr_addr[%0d]: got %0d want %0d", tag, i, mon_wr[wr0+i], exp_wr[i]); end
    end
  endtask

  task automatic test_random_cfgs();
    for (int k = 0; k < 3; k++)
      test_channel_loop($urandom_range(1, 5), $urandom_range(1, 3), 1'b0, 1'b0, "rand");
  endtask

  task automatic test_timeout();
    int st0, d0;
    bit ok;
    st0 = mon_st.size(); d0 = mon_done;
    cu_npix = 4; cu_stall = 1;
    pulse_go(2, 1);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (err === 1'b1) ok = 1'b1;
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL tmo_err: got err 0 want err 1 within 2000 cycles"); end
    // One edge to sample the last request, then 2^TMO_W-1 idle cycles.
    n_checks++; if (cyc - last_mac_cyc != 2 ** TB_TMO) begin
      n_fail++; $display("FAIL tmo_latency: got %0d want %0d", cyc - last_mac_cyc, 2 ** TB_TMO); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy: got %b want 0", busy); end
    n_checks++; if (start !== 2'b00) begin n_fail++; $display("FAIL tmo_start: got %b want 00", start); end
    repeat (5) @(negedge clk);
    n_checks++; if (mon_done - d0 != 0) begin n_fail++; $display("FAIL tmo_all_done: got %0d pulses want 0", mon_done - d0); end
    n_checks++; if (mon_st.size() - st0 != 2) begin n_fail++; $display("FAIL tmo_starts: got %0d want 2", mon_st.size() - st0); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err_sticky: got %b want 1", err); end
    cu_stall = 0;
  endtask

  task automatic test_overrun();
    cu_extra = 1;
    test_channel_loop(2, 1, 1'b0, 1'b1, "overrun");
    cu_extra = 0;
  endtask

  task automatic test_reset_midrun();
    int d0;
    bit ok;
    d0 = mon_done;
    cu_npix = 4;
    pulse_go(2, 3);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (start == 2'b10 && ch_idx == IW'(1)) ok = 1'b1;
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_mid_reach: got no ch1 VAR issue want one within 3000 cycles"); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || all_done !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_flags: got busy %b done %b err %b want 0 0 0", busy, all_done, err); end
    n_checks++; if (start !== 2'b00 || rd_en !== 1'b0 || wr_en !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_strobes: got start %b rd %b wr %b want 00 0 0", start, rd_en, wr_en); end
    n_checks++; if (ch_idx !== '0 || rd_addr !== '0 || wr_addr !== '0) begin
      n_fail++; $display("FAIL rst_mid_addr: got ch %0d rd %0d wr %0d want 0 0 0", ch_idx, rd_addr, wr_addr); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (mon_done - d0 != 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", mon_done - d0); end
    test_channel_loop(2, 1, 1'b0, 1'b0, "rst_restart");
  endtask

  task automatic test_degenerate();
    int st0, d0;
    int cn[2], cc[2];
    cn[0] = 3; cc[0] = 0;
    cn[1] = 0; cc[1] = 2;
    for (int k = 0; k < 2; k++) begin
      st0 = mon_st.size(); d0 = mon_done;
      @(posedge clk); #1;
      cfg_n = NW'(cn[k]); cfg_c = CW'(cc[k]); go = 1'b1;
      @(negedge clk);
      n_checks++; if (all_done !== 1'b0) begin n_fail++; $display("FAIL degen%0d_early: got %b want 0", k, all_done); end
      @(posedge clk); #1;
      go = 1'b0;
      @(negedge clk);
      n_checks++; if (all_done !== 1'b1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL degen%0d_pulse: got done %b busy %b want 1 0", k, all_done, busy); end
      @(negedge clk);
      n_checks++; if (all_done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL degen%0d_after: got done %b busy %b want 0 0", k, all_done, busy); end
      repeat (3) @(negedge clk);
      n_checks++; if (mon_st.size() != st0) begin n_fail++; $display("FAIL degen%0d_start: got %0d commands want 0", k, mon_st.size() - st0); end
      n_checks++; if (mon_done - d0 != 1) begin n_fail++; $display("FAIL degen%0d_count: got %0d want 1", k, mon_done - d0); end
    end
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0; cfg_n = '0; cfg_c = '0;
    cu_npix = 0; cu_extra = 0; cu_stall = 0;
    test_reset();
    test_channel_loop(4, 1, 1'b0, 1'b0, "single");
    test_channel_loop(2, 3, 1'b0, 1'b0, "multi");
    test_random_cfgs();
    test_channel_loop(2, 2, 1'b1, 1'b0, "busy_go");
    test_timeout();
    test_overrun();
    test_reset_midrun();
    test_degenerate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
